// File: rtl/match_logger_pkg.sv
// match_logger_pkg: shared defaults, FIFO entry layout and level-width helper for the match event logger.
package match_logger_pkg;
   localparam int DEPTH_DEF = 8;
   localparam int TS_W_DEF  = 16;
   localparam int CNT_W_DEF = 16;
   typedef struct packed {
      logic                ovf;
      logic [TS_W_DEF-1:0] ts;
   } log_entry_t;
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/match_log_fifo.sv
// match_log_fifo: synchronous show-ahead FIFO; a push into a full FIFO is taken only when a pop happens in the same cycle.
module match_log_fifo
   import match_logger_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int W     = TS_W_DEF + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [lvl_w(DEPTH)-1:0]  level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;
   assign full    = level == LW'(DEPTH);
   assign empty   = level == '0;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rp];
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push && reset_n && !clear) mem[wp] <= din;
   end
endmodule

// File: rtl/match_event_logger.sv
// match_event_logger: timestamps detector matches by bit index into a FIFO with drop tracking.
// Define MATCH_LOGGER_DELTA_EN to report index deltas between events instead of absolute indices.
module match_event_logger
   import match_logger_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int TS_W  = TS_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     bit_valid,
   input  logic                     match,
   input  logic                     clear,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [TS_W-1:0]          rd_ts,
   output logic                     rd_ovf,
   output logic [lvl_w(DEPTH)-1:0]  fifo_level,
   output logic [CNT_W-1:0]         match_count,
   output logic                     overflow_sticky
);
   logic [TS_W-1:0] idx, ts_val;
   logic [TS_W:0]   head;
   logic            ev, pop, full, empty, drop, drop_pending;
   assign ev       = bit_valid & match;
   assign pop      = rd_valid & rd_ready;
   assign drop     = ev & full & ~pop;
   assign rd_valid = ~empty;
   assign rd_ts    = rd_valid ? head[TS_W-1:0] : '0;
   assign rd_ovf   = rd_valid & head[TS_W];
`ifdef MATCH_LOGGER_DELTA_EN
   // gap saturates at all-ones, which doubles as the saturated delta
   logic [TS_W-1:0] gap;
   logic            seen;
   assign ts_val = seen ? gap : idx;
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         gap  <= '0;
         seen <= 1'b0;
      end else if (ev) begin
         gap  <= TS_W'(1);
         seen <= 1'b1;
      end else if (bit_valid && gap != '1) begin
         gap  <= gap + TS_W'(1);
      end
   end
`else
   assign ts_val = idx;
`endif
   match_log_fifo #(.DEPTH(DEPTH), .W(TS_W + 1)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .push    (ev),
      .pop     (pop),
      .din     ({drop_pending, ts_val}),
      .dout    (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );
   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         idx             <= '0;
         drop_pending    <= 1'b0;
         overflow_sticky <= 1'b0;
         match_count     <= '0;
      end else begin
         idx <= idx + TS_W'(bit_valid);
         if (drop) begin
            drop_pending    <= 1'b1;
            overflow_sticky <= 1'b1;
         end else if (ev) begin
            drop_pending    <= 1'b0;
         end
         if (ev && match_count != '1) match_count <= match_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_match_event_logger.sv
// tb_match_event_logger: scoreboard bench for match_event_logger with TS_W=4 and CNT_W=4 to reach wrap and saturation.
module tb_match_event_logger;
   import match_logger_pkg::*;
   localparam int D = 8, TW = 4, CW = 4;
   logic clk = 0, reset_n = 0, bit_valid = 0, match = 0, clear = 0, rd_ready = 0;
   logic rd_valid, rd_ovf, overflow_sticky;
   logic [TW-1:0] rd_ts;
   logic [lvl_w(D)-1:0] fifo_level;
   logic [CW-1:0] match_count;
   int n_cmp = 0, n_bad = 0;
   log_entry_t q[$];
   logic [TW-1:0] m_idx, m_gap;
   logic m_seen, m_pend, m_sticky;
   logic [CW-1:0] m_cnt;

   match_event_logger #(.DEPTH(D), .TS_W(TW), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .bit_valid(bit_valid), .match(match), .clear(clear),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts), .rd_ovf(rd_ovf),
      .fifo_level(fifo_level), .match_count(match_count), .overflow_sticky(overflow_sticky)
   );

   always #5 clk = ~clk;

   // drive one cycle and advance the reference model; expected entries are queued on events
   task automatic cyc(input logic bv, input logic m, input logic rr, input logic clr);
      log_entry_t e;
      logic fire, full_m;
      bit_valid = bv; match = m; rd_ready = rr; clear = clr;
      if (clr || !reset_n) begin
         q.delete();
         m_idx = 0; m_gap = 0; m_seen = 0; m_pend = 0; m_sticky = 0; m_cnt = 0;
      end else begin
         fire = rr && q.size() != 0;
         full_m = q.size() == D;
         if (fire) void'(q.pop_front());
         if (bv && m) begin
            e.ovf = m_pend;
`ifdef MATCH_LOGGER_DELTA_EN
            e.ts = m_seen ? TS_W_DEF'(m_gap) : TS_W_DEF'(m_idx);
`else
            e.ts = TS_W_DEF'(m_idx);
`endif
            if (!full_m || fire) begin
               q.push_back(e);
               m_pend = 0;
            end else begin
               m_pend = 1;
               m_sticky = 1;
            end
            if (m_cnt != '1) m_cnt++;
            m_gap = 1;
            m_seen = 1;
         end else if (bv && m_gap != '1) m_gap++;
         if (bv) m_idx++;
      end
      @(posedge clk); #1;
      bit_valid = 0; match = 0; rd_ready = 0; clear = 0;
   endtask

   task automatic test_reset();
      reset_n = 0;
      cyc(0, 0, 0, 0);
      cyc(1, 1, 1, 0);
      reset_n = 1;
      n_cmp++;
      if ({rd_valid, rd_ts, rd_ovf, fifo_level, match_count, overflow_sticky} !== '0) begin
         n_bad++;
         $display("FAIL reset_values: got v=%b ts=%0d ovf=%b lvl=%0d cnt=%0d sticky=%b want all 0",
                  rd_valid, rd_ts, rd_ovf, fifo_level, match_count, overflow_sticky);
      end
   endtask

   task automatic test_basic();
      log_entry_t e;
      for (int i = 0; i < 8; i++) cyc(1, i == 3 || i == 7, 0, 0);
      n_cmp++;
      if (fifo_level !== 2 || match_count !== 2) begin
         n_bad++;
         $display("FAIL basic_level: got lvl=%0d cnt=%0d want lvl=2 cnt=2", fifo_level, match_count);
      end
      cyc(0, 1, 0, 0);
      n_cmp++;
      if (match_count !== 2 || fifo_level !== 2) begin
         n_bad++;
         $display("FAIL basic_match_no_valid: got cnt=%0d lvl=%0d want cnt=2 lvl=2", match_count, fifo_level);
      end
      n_cmp++;
      if (rd_ts !== 3) begin
         n_bad++;
         $display("FAIL basic_first_ts: got %0d want 3", rd_ts);
      end
      while (q.size() != 0) begin
         e = q[0];
         n_cmp++;
         if (rd_valid !== 1 || rd_ts !== e.ts[TW-1:0] || rd_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL basic_head: got v=%b ts=%0d ovf=%b want v=1 ts=%0d ovf=%b",
                     rd_valid, rd_ts, rd_ovf, e.ts[TW-1:0], e.ovf);
         end
         cyc(0, 0, 1, 0);
      end
      n_cmp++;
      if (rd_valid !== 0 || fifo_level !== 0) begin
         n_bad++;
         $display("FAIL basic_empty: got v=%b lvl=%0d want v=0 lvl=0", rd_valid, fifo_level);
      end
   endtask

   task automatic test_overflow();
      log_entry_t e;
      logic last_ovf;
      last_ovf = 0;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
      n_cmp++;
      if (fifo_level !== 8 || overflow_sticky !== 1 || match_count !== 10) begin
         n_bad++;
         $display("FAIL ovf_full: got lvl=%0d sticky=%b cnt=%0d want lvl=8 sticky=1 cnt=10",
                  fifo_level, overflow_sticky, match_count);
      end
      n_cmp++;
      if (rd_ts !== 0 || rd_ovf !== 0) begin
         n_bad++;
         $display("FAIL ovf_hold_head: got ts=%0d ovf=%b want ts=0 ovf=0", rd_ts, rd_ovf);
      end
      e = q[0];
      n_cmp++;
      if (rd_ts !== e.ts[TW-1:0] || rd_ovf !== e.ovf) begin
         n_bad++;
         $display("FAIL ovf_pop_head: got ts=%0d ovf=%b want ts=%0d ovf=%b", rd_ts, rd_ovf, e.ts[TW-1:0], e.ovf);
      end
      cyc(0, 0, 1, 0);
      cyc(1, 1, 0, 0);
      while (q.size() != 0) begin
         e = q[0];
         n_cmp++;
         if (rd_valid !== 1 || rd_ts !== e.ts[TW-1:0] || rd_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL ovf_drain: got v=%b ts=%0d ovf=%b want v=1 ts=%0d ovf=%b",
                     rd_valid, rd_ts, rd_ovf, e.ts[TW-1:0], e.ovf);
         end
         last_ovf = rd_ovf;
         cyc(0, 0, 1, 0);
      end
      n_cmp++;
      if (last_ovf !== 1 || overflow_sticky !== 1) begin
         n_bad++;
         $display("FAIL ovf_flag_entry: got last_ovf=%b sticky=%b want 1 1", last_ovf, overflow_sticky);
      end
   endtask

   task automatic test_back_to_back();
      log_entry_t e;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0);
      e = q[0];
      n_cmp++;
      if (rd_valid !== 1 || rd_ts !== e.ts[TW-1:0]) begin
         n_bad++;
         $display("FAIL b2b_head: got v=%b ts=%0d want v=1 ts=%0d", rd_valid, rd_ts, e.ts[TW-1:0]);
      end
      cyc(1, 1, 1, 0);
      n_cmp++;
      if (fifo_level !== 8 || overflow_sticky !== 0 || match_count !== 9) begin
         n_bad++;
         $display("FAIL b2b_accept: got lvl=%0d sticky=%b cnt=%0d want lvl=8 sticky=0 cnt=9",
                  fifo_level, overflow_sticky, match_count);
      end
      while (q.size() != 0) begin
         e = q[0];
         n_cmp++;
         if (rd_valid !== 1 || rd_ts !== e.ts[TW-1:0] || rd_ovf !== e.ovf) begin
            n_bad++;
            $display("FAIL b2b_drain: got v=%b ts=%0d ovf=%b want v=1 ts=%0d ovf=%b",
                     rd_valid, rd_ts, rd_ovf, e.ts[TW-1:0], e.ovf);
         end
         cyc(0, 0, 1, 0);
      end
   endtask

   task automatic test_wrap();
      log_entry_t e;
      logic [TW-1:0] want2;
`ifdef MATCH_LOGGER_DELTA_EN
      want2 = 3;
`else
      want2 = 1;
`endif
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 18; i++) cyc(1, i == 14 || i == 17, 0, 0);
      n_cmp++;
      if (rd_ts !== 14) begin
         n_bad++;
         $display("FAIL wrap_first: got %0d want 14", rd_ts);
      end
      cyc(0, 0, 1, 0);
      e = q[0];
      n_cmp++;
      if (rd_valid !== 1 || rd_ts !== want2 || rd_ts !== e.ts[TW-1:0]) begin
         n_bad++;
         $display("FAIL wrap_second: got v=%b ts=%0d want v=1 ts=%0d", rd_valid, rd_ts, want2);
      end
      cyc(0, 0, 1, 0);
   endtask

   task automatic test_gap();
      logic [TW-1:0] want;
`ifdef MATCH_LOGGER_DELTA_EN
      want = 15;
`else
      want = 5;
`endif
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 22; i++) cyc(1, i == 0 || i == 21, i == 1, 0);
      n_cmp++;
      if (rd_valid !== 1 || rd_ts !== want || rd_ts !== q[0].ts[TW-1:0]) begin
         n_bad++;
         $display("FAIL gap_sat: got v=%b ts=%0d want v=1 ts=%0d", rd_valid, rd_ts, want);
      end
      cyc(0, 0, 1, 0);
   endtask

   task automatic test_clear();
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 1);
      n_cmp++;
      if (fifo_level !== 0 || rd_valid !== 0 || match_count !== 0) begin
         n_bad++;
         $display("FAIL clear_state: got lvl=%0d v=%b cnt=%0d want 0 0 0", fifo_level, rd_valid, match_count);
      end
      cyc(1, 1, 0, 0);
      n_cmp++;
      if (rd_valid !== 1 || rd_ts !== 0 || fifo_level !== 1 || rd_ts !== q[0].ts[TW-1:0]) begin
         n_bad++;
         $display("FAIL clear_next_idx: got v=%b ts=%0d lvl=%0d want v=1 ts=0 lvl=1", rd_valid, rd_ts, fifo_level);
      end
   endtask

   task automatic test_midreset();
      log_entry_t e;
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
      e = q[0];
      n_cmp++;
      if (rd_ts !== e.ts[TW-1:0]) begin
         n_bad++;
         $display("FAIL midrst_head: got ts=%0d want %0d", rd_ts, e.ts[TW-1:0]);
      end
      cyc(0, 0, 1, 0);
      reset_n = 0;
      cyc(1, 1, 1, 0);
      reset_n = 1;
      n_cmp++;
      if ({rd_valid, rd_ts, rd_ovf, fifo_level, match_count, overflow_sticky} !== '0) begin
         n_bad++;
         $display("FAIL midrst_values: got v=%b ts=%0d ovf=%b lvl=%0d cnt=%0d sticky=%b want all 0",
                  rd_valid, rd_ts, rd_ovf, fifo_level, match_count, overflow_sticky);
      end
   endtask

   task automatic test_saturation();
      cyc(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0);
      n_cmp++;
      if (match_count !== 15 || match_count !== m_cnt || overflow_sticky !== m_sticky) begin
         n_bad++;
         $display("FAIL cnt_saturate: got cnt=%0d sticky=%b want cnt=15 sticky=%b", match_count, overflow_sticky, m_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_gap();
      test_clear();
      test_midreset();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
